control_fsm: RTL and testbench

- Multicycle control unit that drives the datapath select and enable inputs: RF_WrEn, RF_WrData_sel and RF_B_sel to the decode stage, plus ALU, memory and PC controls.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Decodes the opcode and function field from the latched instruction word.
- Sits beside the datapath; the datapath feeds back only Instr and the ALU Zero flag.

---
 rtl/control_fsm_if.sv | 28 ++
 rtl/control_fsm.sv | 187 ++++++++++++++++++
 tb/tb_control_fsm.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
interface control_fsm_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        Instr_LdEn;
  logic        PC_LdEn;
  logic        PC_sel;
  logic        RF_WrEn;
  logic        RF_WrData_sel;
  logic        RF_B_sel;
  logic        ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        MEM_WrEn;
  logic        ByteOp;
  logic [2:0]  State;

  modport master (
    input  Instr, Zero,
    output Instr_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ALU_Bin_sel, ALU_func, MEM_WrEn, ByteOp, State
  );

  modport slave (
    output Instr, Zero,
    input  Instr_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ALU_Bin_sel, ALU_func, MEM_WrEn, ByteOp, State
  );
endinterface

// File: rtl/control_fsm.sv
// Multicycle control unit: sequences IF/ID/EX/MEM/WB and decodes opcode/func
// into datapath selects and enables; outputs follow the state register and Instr.
module control_fsm (
  input  logic          Clk,
  input  logic          Reset_n,
  control_fsm_if.master bus
);
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned FUNC_W = 4;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b100000;
  localparam logic [OPC_W-1:0] OP_LI    = 6'b111000;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'b111001;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b110000;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b110010;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b110011;
  localparam logic [OPC_W-1:0] OP_B     = 6'b111111;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000000;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000001;
  localparam logic [OPC_W-1:0] OP_LB    = 6'b000011;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b001111;
  localparam logic [OPC_W-1:0] OP_SB    = 6'b000111;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b011111;

  localparam logic [FUNC_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [FUNC_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [FUNC_W-1:0] ALU_AND = 4'b0010;
  localparam logic [FUNC_W-1:0] ALU_OR  = 4'b0011;

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_e;

  state_e state_q, state_d;

  logic [OPC_W-1:0]  opcode;
  logic [FUNC_W-1:0] func;
  logic              unused_instr;

  assign opcode       = bus.Instr[31:26];
  assign func         = bus.Instr[3:0];
  assign unused_instr = ^bus.Instr[25:4];

  // Opcode classification
  logic is_rtype, is_imm_add, is_andi, is_ori, is_b, is_beq, is_bne;
  logic is_lb, is_lw, is_sb, is_sw, is_load, is_store, is_branch, is_legal;

  assign is_rtype   = (opcode == OP_RTYPE);
  assign is_imm_add = (opcode == OP_ADDI) || (opcode == OP_LI) || (opcode == OP_LUI);
  assign is_andi    = (opcode == OP_ANDI);
  assign is_ori     = (opcode == OP_ORI);
  assign is_b       = (opcode == OP_B);
  assign is_beq     = (opcode == OP_BEQ);
  assign is_bne     = (opcode == OP_BNE);
  assign is_lb      = (opcode == OP_LB);
  assign is_lw      = (opcode == OP_LW);
  assign is_sb      = (opcode == OP_SB);
  assign is_sw      = (opcode == OP_SW);
  assign is_load    = is_lb || is_lw;
  assign is_store   = is_sb || is_sw;
  assign is_branch  = is_b || is_beq || is_bne;
  assign is_legal   = is_rtype || is_imm_add || is_andi || is_ori ||
                      is_branch || is_load || is_store;

  // ALU controls, shared by EX, MEM and WB of the same instruction
  logic [FUNC_W-1:0] alu_func_c;
  logic              alu_bin_sel_c;

  always_comb begin
    alu_func_c    = ALU_ADD;
    alu_bin_sel_c = 1'b0;
    if (is_rtype) begin
      alu_func_c = func;
    end else if (is_imm_add || is_load || is_store) begin
      alu_bin_sel_c = 1'b1;
    end else if (is_andi) begin
      alu_func_c    = ALU_AND;
      alu_bin_sel_c = 1'b1;
    end else if (is_ori) begin
      alu_func_c    = ALU_OR;
      alu_bin_sel_c = 1'b1;
    end else if (is_branch) begin
      alu_func_c = ALU_SUB;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  logic              instr_lden_c, pc_lden_c, pc_sel_c, rf_wren_c, rf_wrdata_sel_c;
  logic              rf_b_sel_c, alu_bin_c, mem_wren_c, byteop_c;
  logic [FUNC_W-1:0] alu_fn_c;

  always_comb begin
    state_d         = S_IF;
    instr_lden_c    = 1'b0;
    pc_lden_c       = 1'b0;
    pc_sel_c        = 1'b0;
    rf_wren_c       = 1'b0;
    rf_wrdata_sel_c = 1'b0;
    rf_b_sel_c      = 1'b0;
    alu_bin_c       = 1'b0;
    alu_fn_c        = ALU_ADD;
    mem_wren_c      = 1'b0;
    byteop_c        = 1'b0;

    unique case (state_q)
      S_IF: begin
        instr_lden_c = 1'b1;
        state_d      = S_ID;
      end
      S_ID: begin
        if (is_legal) begin
          rf_b_sel_c = is_store || is_beq || is_bne;
          state_d    = S_EX;
        end else begin
          pc_lden_c = 1'b1;
        end
      end
      S_EX: begin
        alu_fn_c  = alu_func_c;
        alu_bin_c = alu_bin_sel_c;
        if (is_branch) begin
          rf_b_sel_c = 1'b1;
          pc_lden_c  = 1'b1;
          pc_sel_c   = is_b || (is_beq && bus.Zero) || (is_bne && !bus.Zero);
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_legal) begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_fn_c  = alu_func_c;
        alu_bin_c = alu_bin_sel_c;
        if (is_store) begin
          mem_wren_c = 1'b1;
          byteop_c   = is_sb;
          pc_lden_c  = 1'b1;
        end else if (is_load) begin
          byteop_c = is_lb;
          state_d  = S_WB;
        end
      end
      S_WB: begin
        alu_fn_c        = alu_func_c;
        alu_bin_c       = alu_bin_sel_c;
        rf_wren_c       = 1'b1;
        pc_lden_c       = 1'b1;
        rf_wrdata_sel_c = is_load;
      end
      default: state_d = S_IF;
    endcase

    // Reset overrides everything so no write or fetch is issued while held
    if (!Reset_n) begin
      instr_lden_c    = 1'b0;
      pc_lden_c       = 1'b0;
      pc_sel_c        = 1'b0;
      rf_wren_c       = 1'b0;
      rf_wrdata_sel_c = 1'b0;
      rf_b_sel_c      = 1'b0;
      alu_bin_c       = 1'b0;
      alu_fn_c        = ALU_ADD;
      mem_wren_c      = 1'b0;
      byteop_c        = 1'b0;
    end
  end

  assign bus.Instr_LdEn    = instr_lden_c;
  assign bus.PC_LdEn       = pc_lden_c;
  assign bus.PC_sel        = pc_sel_c;
  assign bus.RF_WrEn       = rf_wren_c;
  assign bus.RF_WrData_sel = rf_wrdata_sel_c;
  assign bus.RF_B_sel      = rf_b_sel_c;
  assign bus.ALU_Bin_sel   = alu_bin_c;
  assign bus.ALU_func      = alu_fn_c;
  assign bus.MEM_WrEn      = mem_wren_c;
  assign bus.ByteOp        = byteop_c;
  assign bus.State         = state_q;
endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: expected per-cycle control vectors are
// queued with each instruction and compared on the falling edge.
module tb_control_fsm;
  logic Clk;
  logic Reset_n;

  control_fsm_if bus ();

  control_fsm dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    string       tag;
    logic [16:0] vec;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // {Instr_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
  //  ALU_Bin_sel, ALU_func[3:0], MEM_WrEn, ByteOp, State[2:0]}
  function automatic logic [16:0] ev(input logic [2:0] st, input logic ild, input logic pld,
                                     input logic psel, input logic rfw, input logic wds,
                                     input logic bsel, input logic bin, input logic [3:0] fn,
                                     input logic memw, input logic bop);
    return {ild, pld, psel, rfw, wds, bsel, bin, fn, memw, bop, st};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.Instr_LdEn, bus.PC_LdEn, bus.PC_sel, bus.RF_WrEn, bus.RF_WrData_sel,
            bus.RF_B_sel, bus.ALU_Bin_sel, bus.ALU_func, bus.MEM_WrEn, bus.ByteOp, bus.State};
  endfunction

  task automatic push(input string tag, input logic [16:0] v);
    exp_t e;
    e.tag = tag;
    e.vec = v;
    sb_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.tag, 32'(observed()), 32'(e.vec));
    end
  end

  // Called at posedge+1 with the FSM in S_IF; lets n cycles elapse.
  task automatic run(input logic [31:0] instr, input logic zero, input int n);
    bus.Instr = instr;
    bus.Zero  = zero;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n   = 1'b0;
    bus.Instr = 32'h8000_0030;
    bus.Zero  = 1'b0;
    @(posedge Clk);
    #1;
    push("reset0", ev(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("reset1", ev(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // R-type add
    push("rt_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("rt_id", ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("rt_ex", ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("rt_wb", ev(3'd4, 0, 1, 0, 1, 0, 0, 0, 4'h0, 0, 0));
    run(32'h8000_0030, 1'b0, 4);

    // R-type with func 0101
    push("rt5_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("rt5_id", ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("rt5_ex", ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 4'h5, 0, 0));
    push("rt5_wb", ev(3'd4, 0, 1, 0, 1, 0, 0, 0, 4'h5, 0, 0));
    run(32'h8000_0035, 1'b1, 4);

    // lw
    push("lw_if",  ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("lw_id",  ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("lw_ex",  ev(3'd2, 0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0));
    push("lw_mem", ev(3'd3, 0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0));
    push("lw_wb",  ev(3'd4, 0, 1, 0, 1, 1, 0, 1, 4'h0, 0, 0));
    run(32'h3C22_0004, 1'b0, 5);

    // lb
    push("lb_if",  ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("lb_id",  ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("lb_ex",  ev(3'd2, 0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0));
    push("lb_mem", ev(3'd3, 0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 1));
    push("lb_wb",  ev(3'd4, 0, 1, 0, 1, 1, 0, 1, 4'h0, 0, 0));
    run(32'h0C22_0008, 1'b0, 5);

    // sb
    push("sb_if",  ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("sb_id",  ev(3'd1, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0));
    push("sb_ex",  ev(3'd2, 0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0));
    push("sb_mem", ev(3'd3, 0, 1, 0, 0, 0, 0, 1, 4'h0, 1, 1));
    run(32'h1C22_0001, 1'b0, 4);

    // sw
    push("sw_if",  ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("sw_id",  ev(3'd1, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0));
    push("sw_ex",  ev(3'd2, 0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0));
    push("sw_mem", ev(3'd3, 0, 1, 0, 0, 0, 0, 1, 4'h0, 1, 0));
    run(32'h7C22_0010, 1'b0, 4);

    // Branches: beq Z=1, beq Z=0, bne Z=0, bne Z=1, b
    push("beq1_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("beq1_id", ev(3'd1, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0));
    push("beq1_ex", ev(3'd2, 0, 1, 1, 0, 0, 1, 0, 4'h1, 0, 0));
    run(32'h0022_0010, 1'b1, 3);
    push("beq0_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("beq0_id", ev(3'd1, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0));
    push("beq0_ex", ev(3'd2, 0, 1, 0, 0, 0, 1, 0, 4'h1, 0, 0));
    run(32'h0022_0010, 1'b0, 3);
    push("bne0_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("bne0_id", ev(3'd1, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0));
    push("bne0_ex", ev(3'd2, 0, 1, 1, 0, 0, 1, 0, 4'h1, 0, 0));
    run(32'h0422_0010, 1'b0, 3);
    push("bne1_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("bne1_id", ev(3'd1, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0));
    push("bne1_ex", ev(3'd2, 0, 1, 0, 0, 0, 1, 0, 4'h1, 0, 0));
    run(32'h0422_0010, 1'b1, 3);
    push("b_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("b_id", ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("b_ex", ev(3'd2, 0, 1, 1, 0, 0, 1, 0, 4'h1, 0, 0));
    run(32'hFC00_0020, 1'b0, 3);

    // andi and ori
    push("andi_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("andi_id", ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("andi_ex", ev(3'd2, 0, 0, 0, 0, 0, 0, 1, 4'h2, 0, 0));
    push("andi_wb", ev(3'd4, 0, 1, 0, 1, 0, 0, 1, 4'h2, 0, 0));
    run(32'hC822_00FF, 1'b0, 4);
    push("ori_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("ori_id", ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("ori_ex", ev(3'd2, 0, 0, 0, 0, 0, 0, 1, 4'h3, 0, 0));
    push("ori_wb", ev(3'd4, 0, 1, 0, 1, 0, 0, 1, 4'h3, 0, 0));
    run(32'hCC22_00F1, 1'b0, 4);

    // Illegal opcode acts as a 2-cycle NOP
    push("ill_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("ill_id", ev(3'd1, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    run(32'hA800_0000, 1'b0, 2);
    push("post_ill_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));

    // Async reset mid-WB of an addi
    push("addi_id", ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("addi_ex", ev(3'd2, 0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0));
    push("addi_wb", ev(3'd4, 0, 1, 0, 1, 0, 0, 1, 4'h0, 0, 0));
    bus.Instr = 32'hC022_0007;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_rfwren", 32'(bus.RF_WrEn), 32'd0);
    check("arst_state",  32'(bus.State),   32'd0);
    check("arst_pclden", 32'(bus.PC_LdEn), 32'd0);
    push("arst_hold", ev(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    @(negedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // Recovery: li runs a full 4-cycle sequence
    push("li_if", ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("li_id", ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    push("li_ex", ev(3'd2, 0, 0, 0, 0, 0, 0, 1, 4'h0, 0, 0));
    push("li_wb", ev(3'd4, 0, 1, 0, 1, 0, 0, 1, 4'h0, 0, 0));
    run(32'hE022_1234, 1'b0, 4);

    @(negedge Clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
